ifu_idu_buf: RTL

//  - Receiving end of the IFU fetch handshake. Accepts {pc, pc_next, inst} packets from the IFU on

---
 rtl/meteor_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/ifu_idu_buf.sv | 70 +++++++
 3 files changed

// File: rtl/meteor_pkg.sv
// Shared fetch-path types: the IFU->IDU packet layout and its packed width.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package meteor_pkg;

    localparam int unsigned ADDR_W = `ADDR_WIDTH;
    localparam int unsigned INST_W = `DATA_WIDTH;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_next;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

    localparam int unsigned FETCH_PKT_W = $bits(fetch_pkt_t);

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x WIDTH in-order FIFO with flush; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [WIDTH-1:0]     rd_data,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned PTR_W = CNT_WIDTH - 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 do_push, do_pop;

    always_comb begin
        full    = (cnt_q == CNT_WIDTH'(DEPTH));
        empty   = (cnt_q == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Flush wins over any same-cycle push/pop: the pushed packet is dropped.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
                2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only visible while cnt is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign cnt     = cnt_q;

endmodule

// File: rtl/ifu_idu_buf.sv
// IFU->IDU fetch buffer: queues fetch packets in order, back-pressures the IFU, flushes on redirect.
module ifu_idu_buf
    import meteor_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = meteor_pkg::ADDR_W,
    parameter int unsigned INST_WIDTH = meteor_pkg::INST_W,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_ifu_valid,
    output logic                  o_ifu_ready,
    input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
    input  logic [ADDR_WIDTH-1:0] i_ifu_pc_next,
    input  logic [INST_WIDTH-1:0] i_ifu_inst,
    input  logic                  i_exu_jmp_en,
    output logic                  o_idu_valid,
    input  logic                  i_idu_ready,
    output logic [ADDR_WIDTH-1:0] o_idu_pc,
    output logic [ADDR_WIDTH-1:0] o_idu_pc_next,
    output logic [INST_WIDTH-1:0] o_idu_inst,
    output logic [CNT_WIDTH-1:0]  o_buf_cnt
);

    fetch_pkt_t wr_pkt, rd_pkt;
    logic       fifo_full, fifo_empty;
    logic       push, pop;

    always_comb begin
        wr_pkt.pc      = i_ifu_pc;
        wr_pkt.pc_next = i_ifu_pc_next;
        wr_pkt.inst    = i_ifu_inst;
    end

    // Ready depends only on registered occupancy, never on the IDU side.
    assign o_ifu_ready = ~fifo_full;
    assign o_idu_valid = ~fifo_empty;
    assign push        = i_ifu_valid & o_ifu_ready;
    assign pop         = o_idu_valid & i_idu_ready;

    sync_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (FETCH_PKT_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk     (i_sys_clk),
        .rst     (i_sys_rst),
        .push    (push),
        .pop     (pop),
        .flush   (i_exu_jmp_en),
        .wr_data (wr_pkt),
        .rd_data (rd_pkt),
        .cnt     (o_buf_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        o_idu_pc      = '0;
        o_idu_pc_next = '0;
        o_idu_inst    = '0;
        if (o_idu_valid) begin
            o_idu_pc      = rd_pkt.pc;
            o_idu_pc_next = rd_pkt.pc_next;
            o_idu_inst    = rd_pkt.inst;
        end
    end

endmodule
